alu_share_arb: RTL
==================

# alu_share_arb

Shares one combinational ALU between two requesters (the two issue lanes of the dual-issue pipeline) through valid/ready handshakes. The block arbitrates round-robin, registers one result per cycle, and returns it on a single response port tagged with requester ID and instruction tag. It sits between issue and writeback, replacing a second ALU instance in area-constrained builds.

## Interface
Parameters:
- TAG_W, 5, width of the per-request instruction tag.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rstn  in  1  reset, synchronous, active-low.
- flush  in  1  pipeline flush; drops the held result and blocks acceptance this cycle.
- req_valid  in  2  per-requester request valid; bit i is requester i.
- req_ready  out  2  per-requester accept; combinational.
- req_a  in  2×32  operand A per requester.
- req_b  in  2×32  operand B per requester.
- req_op  in  2×12  one-hot ALU select per requester.
- req_tag  in  2×TAG_W  opaque tag per requester.
- resp_valid  out  1  result register holds a valid result.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  1  requester index of the held result.
- resp_tag  out  TAG_W  tag of the held result.
- resp_y  out  32  ALU result.
- resp_err  out  1  the request op was not one-hot.

## Operation
- Op bit encoding, fixed:
  - bit0 ADD, bit1 SUB, bit2 SLT (signed), bit3 SLTU.
  - bit4 AND, bit5 OR, bit6 NOR, bit7 XOR.
  - bit8 SLL, bit9 SRL, bit10 SRA, bit11 pass B.
  - Shift amount is b[4:0].
- can_accept = !flush & (!resp_valid | resp_ready).
- Grant:
  - Only one requester valid: that requester wins.
  - Both valid: the requester selected by the priority bit `prio` wins.
  - req_ready[i] = can_accept & grant[i].
  - At most one req_ready bit is high in any cycle.
- `prio` update: after a successful grant to requester i, prio becomes 1−i. It does not change when no grant occurs.
- On accept:
  - Load the result register with y, id, tag and err.
  - Set resp_valid = 1.
- Illegal op (req_op not exactly one-hot, including all-zero):
  - y = 0 and err = 1.
  - The request is still accepted and returned. It is never stalled or dropped.
- Result register when the response is drained with no new accept: resp_valid goes to 0. resp_y, resp_tag and resp_id keep their last values.
- Flush:
  - At the next edge resp_valid = 0.
  - No request is accepted in the flush cycle.
  - `prio` is unchanged.
- Requesters must hold a, b, op and tag stable while valid is high and ready is low. The block does not check this.

## Timing
- Reset (rstn low at an edge):
  - resp_valid, resp_id and resp_err = 0.
  - resp_y = 0 and resp_tag = 0.
  - prio = 0, so requester 0 is preferred first.
  - req_ready = 0 while rstn is low.
- Latency: a request accepted at edge N is visible on resp_* after edge N, one cycle.
- Throughput: one result per cycle while resp_ready is held high.
- Backpressure:
  - resp_valid = 1 and resp_ready = 0: all response outputs hold stable, and req_ready = 00.
  - Drain and accept in the same cycle are allowed, with no bubble.
- Fairness: with both requesters continuously valid and resp_ready = 1, grants alternate 0,1,0,1… Starvation is never more than one cycle.
- Simultaneous flush and resp_ready: flush wins, so the register empties and nothing is accepted.
- rstn low during backpressure: the held result is discarded.

## Structure
- Package alu_pkg holds:
  - The op one-hot constants OP_ADD=12'h001 … OP_PASSB=12'h800.
  - The localparam NREQ=2.
  - A request struct typedef {a, b, op, tag}.
- Sub-modules:
  - The existing shared ALU module is instantiated once, operand-muxed by the grant.
  - rr_arb2 is a two-way round-robin arbiter holding `prio`. It outputs a one-hot grant from the valid bits and updates on an `advance` strobe.
- The one-hot check ($onehot on the selected op) lives in alu_share_arb.

## Test plan
- Req0 ADD, a=5, b=7, op=12'h001, tag=3, resp_ready=1 → next cycle resp_valid=1, resp_y=12, resp_id=0, resp_tag=3, resp_err=0.
- Both requesters valid for 4 cycles after reset; req0 SUB a=10 b=3, req1 SRA a=32'h8000_0000 b=4 → resp_id sequence 0,1,0,1, with resp_y alternating 7 and 32'hF800_0000.
- resp_ready=0 for 3 cycles with one result held → resp_* stable and req_ready=00 throughout. Then resp_ready=1 with req1 valid → drain and accept in the same cycle, next result one cycle later.
- Req1 op=12'h003 (illegal), a=1, b=1 → resp_err=1, resp_y=0, resp_id=1, and the handshake completes normally.
- Result held with resp_ready=0, then flush=1 and req0 valid → next cycle resp_valid=0 and req0 not accepted. The following cycle req0 is accepted.
- Assert rstn=0 mid-stream with prio=1 → after release all outputs are 0, and the first dual-valid grant goes to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Op encoding, requester count and request record shared by the ALU
// sharing block, its sub-modules and their users.
package alu_pkg;

  localparam int NREQ      = 2;
  localparam int OP_W      = 12;
  localparam int REQ_TAG_W = 5;

  localparam logic [OP_W-1:0] OP_ADD   = 12'h001;
  localparam logic [OP_W-1:0] OP_SUB   = 12'h002;
  localparam logic [OP_W-1:0] OP_SLT   = 12'h004;
  localparam logic [OP_W-1:0] OP_SLTU  = 12'h008;
  localparam logic [OP_W-1:0] OP_AND   = 12'h010;
  localparam logic [OP_W-1:0] OP_OR    = 12'h020;
  localparam logic [OP_W-1:0] OP_NOR   = 12'h040;
  localparam logic [OP_W-1:0] OP_XOR   = 12'h080;
  localparam logic [OP_W-1:0] OP_SLL   = 12'h100;
  localparam logic [OP_W-1:0] OP_SRL   = 12'h200;
  localparam logic [OP_W-1:0] OP_SRA   = 12'h400;
  localparam logic [OP_W-1:0] OP_PASSB = 12'h800;

  typedef struct packed {
    logic [31:0]          a;
    logic [31:0]          b;
    logic [OP_W-1:0]      op;
    logic [REQ_TAG_W-1:0] tag;
  } alu_req_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU selected by a one-hot op; any other op value
// produces zero.
module alu_core
  import alu_pkg::*;
(
  input  logic [31:0]     a_i,
  input  logic [31:0]     b_i,
  input  logic [OP_W-1:0] op_i,
  output logic [31:0]     y_o
);

  logic [4:0] shamt;

  // Result select on the one-hot op
  always_comb begin
    y_o   = 32'h0000_0000;
    shamt = b_i[4:0];
    case (op_i)
      OP_ADD:   y_o = a_i + b_i;
      OP_SUB:   y_o = a_i - b_i;
      OP_SLT:   y_o = {31'h0000_0000, ($signed(a_i) < $signed(b_i))};
      OP_SLTU:  y_o = {31'h0000_0000, (a_i < b_i)};
      OP_AND:   y_o = a_i & b_i;
      OP_OR:    y_o = a_i | b_i;
      OP_NOR:   y_o = ~(a_i | b_i);
      OP_XOR:   y_o = a_i ^ b_i;
      OP_SLL:   y_o = a_i << shamt;
      OP_SRL:   y_o = a_i >> shamt;
      OP_SRA:   y_o = $unsigned($signed(a_i) >>> shamt);
      OP_PASSB: y_o = b_i;
      default:  y_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from the valid bits, the
// priority pointer moves past the winner on each advance strobe.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic prio_q;
  logic prio_d;

  // Lone requester wins; on a tie the prio holder wins
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = prio_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  // A grant to requester 0 hands priority to 1, and vice versa
  always_comb begin
    prio_d = prio_q;
    if (advance_i && (grant_o != 2'b00)) begin
      prio_d = grant_o[0];
    end else begin
      prio_d = prio_q;
    end
  end

  // Priority pointer register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// One ALU shared by two issue lanes: round-robin grant, one registered
// result per cycle, returned with requester id and tag.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][31:0]      req_a,
  input  logic [NREQ-1:0][31:0]      req_b,
  input  logic [NREQ-1:0][OP_W-1:0]  req_op,
  input  logic [NREQ-1:0][TAG_W-1:0] req_tag,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic                       resp_id,
  output logic [TAG_W-1:0]           resp_tag,
  output logic [31:0]                resp_y,
  output logic                       resp_err
);

  logic [NREQ-1:0] grant;
  logic            can_accept;
  logic            accept;
  logic            sel_id;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic [OP_W-1:0] sel_op;
  logic [TAG_W-1:0] sel_tag;
  logic            sel_err;
  logic [31:0]     alu_y;
  logic [31:0]     sel_y;

  logic             valid_q, valid_d;
  logic             id_q, id_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      y_q, y_d;
  logic             err_q, err_d;

  rr_arb2 u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .valid_i   (req_valid),
    .advance_i (accept),
    .grant_o   (grant)
  );

  // Flush and an undrained result both block acceptance; nothing is
  // offered while reset is held.
  always_comb begin
    can_accept = 1'b0;
    if (rstn && !flush && (!valid_q || resp_ready)) begin
      can_accept = 1'b1;
    end else begin
      can_accept = 1'b0;
    end
    req_ready = grant & {NREQ{can_accept}};
    accept    = |req_ready;
  end

  // Operand mux steered by the granted requester
  always_comb begin
    sel_id  = grant[1];
    sel_a   = req_a[sel_id];
    sel_b   = req_b[sel_id];
    sel_op  = req_op[sel_id];
    sel_tag = req_tag[sel_id];
  end

  alu_core u_alu (
    .a_i  (sel_a),
    .b_i  (sel_b),
    .op_i (sel_op),
    .y_o  (alu_y)
  );

  // Non-one-hot ops still complete, flagged and with a zero result
  always_comb begin
    sel_err = !$onehot(sel_op);
    if (sel_err) begin
      sel_y = 32'h0000_0000;
    end else begin
      sel_y = alu_y;
    end
  end

  // Result register next state: load on accept, empty on drain or flush
  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    tag_d   = tag_q;
    y_d     = y_q;
    err_d   = err_q;
    if (accept) begin
      valid_d = 1'b1;
      id_d    = sel_id;
      tag_d   = sel_tag;
      y_d     = sel_y;
      err_d   = sel_err;
    end else if (flush || resp_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Result register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      id_q    <= 1'b0;
      tag_q   <= '0;
      y_q     <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
      tag_q   <= tag_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  assign resp_valid = valid_q;
  assign resp_id    = id_q;
  assign resp_tag   = tag_q;
  assign resp_y     = y_q;
  assign resp_err   = err_q;

endmodule
